// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: FSM states,
// opcodes, instruction classes, immediate-select one-hots and datapath select codes.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      CL_R,
      CL_OPIMM,
      CL_LOAD,
      CL_STORE,
      CL_LUI,
      CL_AUIPC,
      CL_BRANCH,
      CL_JAL,
      CL_JALR,
      CL_ILL
   } iclass_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // One-hot encoding shared with the immediate-extension unit.
   localparam logic [5:0] EXT_NONE = 6'b000000;
   localparam logic [5:0] EXT_I    = 6'b010000;
   localparam logic [5:0] EXT_S    = 6'b001000;
   localparam logic [5:0] EXT_B    = 6'b000100;
   localparam logic [5:0] EXT_U    = 6'b000010;
   localparam logic [5:0] EXT_J    = 6'b000001;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_PASSB = 2'b11;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MDR = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

endpackage

// File: rtl/mc_opdec.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction
// class, the immediate-extension one-hot select and a legality flag.
module mc_opdec
   import mc_pkg::*;
(
   input  logic [6:0] op,
   output iclass_e    cls,
   output logic [5:0] ext_op,
   output logic       legal
);

   always_comb begin
      cls    = CL_ILL;
      ext_op = EXT_NONE;
      legal  = 1'b1;
      case (op)
         OP_R:      begin cls = CL_R;      ext_op = EXT_NONE; end
         OP_OPIMM:  begin cls = CL_OPIMM;  ext_op = EXT_I;    end
         OP_LOAD:   begin cls = CL_LOAD;   ext_op = EXT_I;    end
         OP_STORE:  begin cls = CL_STORE;  ext_op = EXT_S;    end
         OP_LUI:    begin cls = CL_LUI;    ext_op = EXT_U;    end
         OP_AUIPC:  begin cls = CL_AUIPC;  ext_op = EXT_U;    end
         OP_BRANCH: begin cls = CL_BRANCH; ext_op = EXT_B;    end
         OP_JAL:    begin cls = CL_JAL;    ext_op = EXT_J;    end
         OP_JALR:   begin cls = CL_JALR;   ext_op = EXT_I;    end
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// ALU and one handshaked memory port. Only the state is registered.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic [6:0] Op,
   input  logic       br_cond,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       aluout_we,
   output logic       RegWrite,
   output logic [1:0] WDSel,
   output logic [5:0] EXTOp,
   output logic       illegal,
   output logic [2:0] state
);

   state_e     state_q, state_d;
   iclass_e    cls;
   logic [5:0] dec_ext;
   logic       dec_legal;

   mc_opdec u_opdec (
      .op     (Op),
      .cls    (cls),
      .ext_op (dec_ext),
      .legal  (dec_legal)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      IorD      = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSrc     = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      aluout_we = 1'b0;
      RegWrite  = 1'b0;
      WDSel     = WD_ALU;
      EXTOp     = EXT_NONE;
      illegal   = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_FETCH;

         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = ST_DECODE;
            end
         end

         // ALUOut gets OldPC+imm here so AUIPC and branch/jump targets are ready.
         ST_DECODE: begin
            EXTOp     = dec_ext;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 1'b1;
            aluout_we = 1'b1;
            state_d   = dec_legal ? ST_EXEC : ST_TRAP;
         end

         ST_EXEC: begin
            EXTOp   = dec_ext;
            state_d = ST_WB;
            case (cls)
               CL_R: begin
                  ALUOp     = ALU_FUNCT;
                  aluout_we = 1'b1;
               end
               CL_OPIMM: begin
                  ALUSrcB   = 1'b1;
                  ALUOp     = ALU_FUNCT;
                  aluout_we = 1'b1;
               end
               CL_LOAD, CL_STORE: begin
                  ALUSrcB   = 1'b1;
                  aluout_we = 1'b1;
                  state_d   = ST_MEM;
               end
               CL_LUI: begin
                  ALUSrcB   = 1'b1;
                  ALUOp     = ALU_PASSB;
                  aluout_we = 1'b1;
               end
               // ALUOut keeps the branch target computed in DECODE.
               CL_BRANCH: begin
                  ALUOp   = ALU_SUB;
                  PCWrite = br_cond;
                  PCSrc   = br_cond;
                  state_d = ST_FETCH;
               end
               CL_JALR: begin
                  ALUSrcB   = 1'b1;
                  aluout_we = 1'b1;
               end
               default: ;
            endcase
         end

         ST_MEM: begin
            EXTOp   = dec_ext;
            mem_req = 1'b1;
            IorD    = 1'b1;
            mem_we  = (cls == CL_STORE);
            if (mem_ack) state_d = (cls == CL_STORE) ? ST_FETCH : ST_WB;
         end

         ST_WB: begin
            EXTOp    = dec_ext;
            RegWrite = 1'b1;
            state_d  = ST_FETCH;
            case (cls)
               CL_LOAD: WDSel = WD_MDR;
               CL_JAL, CL_JALR: begin
                  WDSel   = WD_PC;
                  PCWrite = 1'b1;
                  PCSrc   = 1'b1;
               end
               default: WDSel = WD_ALU;
            endcase
         end

         ST_TRAP: illegal = 1'b1;

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: per-cycle input/expected-output records
// plus hand-written sequences for async reset and the absorbing TRAP state.
module tb_mc_ctrl;

   localparam logic [6:0] O_R     = 7'b0110011;
   localparam logic [6:0] O_ADDI  = 7'b0010011;
   localparam logic [6:0] O_LW    = 7'b0000011;
   localparam logic [6:0] O_SW    = 7'b0100011;
   localparam logic [6:0] O_LUI   = 7'b0110111;
   localparam logic [6:0] O_AUIPC = 7'b0010111;
   localparam logic [6:0] O_BEQ   = 7'b1100011;
   localparam logic [6:0] O_JAL   = 7'b1101111;
   localparam logic [6:0] O_JALR  = 7'b1100111;
   localparam logic [6:0] O_BAD   = 7'b1111111;

   logic       clk, rstn;
   logic [6:0] Op;
   logic       br_cond, mem_ack;
   logic       mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc;
   logic       ALUSrcA, ALUSrcB, aluout_we, RegWrite, illegal;
   logic [1:0] ALUOp, WDSel;
   logic [5:0] EXTOp;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   mc_ctrl dut (
      .clk       (clk),
      .rstn      (rstn),
      .Op        (Op),
      .br_cond   (br_cond),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .IorD      (IorD),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .PCSrc     (PCSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .aluout_we (aluout_we),
      .RegWrite  (RegWrite),
      .WDSel     (WDSel),
      .EXTOp     (EXTOp),
      .illegal   (illegal),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] act;
   assign act = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB,
                 ALUOp, aluout_we, RegWrite, WDSel, EXTOp, illegal, state};

   function automatic logic [23:0] ex(
      input logic [2:0] st, input logic req, input logic we, input logic iord,
      input logic irw, input logic pcw, input logic pcsrc, input logic sa,
      input logic sb, input logic [1:0] aop, input logic awe, input logic rw,
      input logic [1:0] wd, input logic [5:0] ext, input logic ill);
      return {req, we, iord, irw, pcw, pcsrc, sa, sb, aop, awe, rw, wd, ext, ill, st};
   endfunction

   // Common rows
   function automatic logic [23:0] e_fetch(input logic ack);
      return ex(3'd1, 1, 0, 0, ack, ack, 0, 0, 0, 2'b00, 0, 0, 2'b00, 6'b0, 0);
   endfunction
   function automatic logic [23:0] e_dec(input logic [5:0] ext);
      return ex(3'd2, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 1, 0, 2'b00, ext, 0);
   endfunction

   typedef struct {
      string       name;
      logic [6:0]  op;
      logic        ack;
      logic        br;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input logic [6:0] o, input logic a,
                      input logic b, input logic [23:0] e);
      vec_t v;
      v.name = n; v.op = o; v.ack = a; v.br = b; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string n, input logic [23:0] got, input logic [23:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %06h expected %06h (t=%0t)", n, got, want, $time);
      end
   endtask

   task automatic fetch_row(input string n, input logic [6:0] o);
      add(n, o, 1'b1, 1'b0, e_fetch(1'b1));
   endtask

   initial begin
      rstn = 1'b0; Op = O_ADDI; br_cond = 1'b0; mem_ack = 1'b0;

      // ADDI, with one idle FETCH wait first check of IDLE after reset release
      add("addi_idle",  O_ADDI, 0, 0, ex(3'd0, 0,0,0,0,0,0,0,0,2'b00,0,0,2'b00,6'b0,0));
      fetch_row("addi_fetch", O_ADDI);
      add("addi_dec",   O_ADDI, 1, 0, e_dec(6'b010000));
      add("addi_exec",  O_ADDI, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,1,2'b10,1,0,2'b00,6'b010000,0));
      add("addi_wb",    O_ADDI, 1, 0, ex(3'd5, 0,0,0,0,0,0,0,0,2'b00,0,1,2'b00,6'b010000,0));
      // LW with two wait cycles in MEM
      add("lw_fwait",   O_LW, 0, 0, e_fetch(1'b0));
      fetch_row("lw_fetch", O_LW);
      add("lw_dec",     O_LW, 0, 0, e_dec(6'b010000));
      add("lw_exec",    O_LW, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,1,2'b00,1,0,2'b00,6'b010000,0));
      add("lw_mem0",    O_LW, 0, 0, ex(3'd4, 1,0,1,0,0,0,0,0,2'b00,0,0,2'b00,6'b010000,0));
      add("lw_mem1",    O_LW, 0, 0, ex(3'd4, 1,0,1,0,0,0,0,0,2'b00,0,0,2'b00,6'b010000,0));
      add("lw_mem2",    O_LW, 1, 0, ex(3'd4, 1,0,1,0,0,0,0,0,2'b00,0,0,2'b00,6'b010000,0));
      add("lw_wb",      O_LW, 0, 0, ex(3'd5, 0,0,0,0,0,0,0,0,2'b00,0,1,2'b01,6'b010000,0));
      // SW zero-wait
      fetch_row("sw_fetch", O_SW);
      add("sw_dec",     O_SW, 0, 0, e_dec(6'b001000));
      add("sw_exec",    O_SW, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,1,2'b00,1,0,2'b00,6'b001000,0));
      add("sw_mem",     O_SW, 1, 0, ex(3'd4, 1,1,1,0,0,0,0,0,2'b00,0,0,2'b00,6'b001000,0));
      // BEQ taken / not taken
      fetch_row("beqt_fetch", O_BEQ);
      add("beqt_dec",   O_BEQ, 0, 1, e_dec(6'b000100));
      add("beqt_exec",  O_BEQ, 0, 1, ex(3'd3, 0,0,0,0,1,1,0,0,2'b01,0,0,2'b00,6'b000100,0));
      fetch_row("beqn_fetch", O_BEQ);
      add("beqn_dec",   O_BEQ, 0, 0, e_dec(6'b000100));
      add("beqn_exec",  O_BEQ, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,0,2'b01,0,0,2'b00,6'b000100,0));
      // JAL
      fetch_row("jal_fetch", O_JAL);
      add("jal_dec",    O_JAL, 0, 0, e_dec(6'b000001));
      add("jal_exec",   O_JAL, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,0,2'b00,0,0,2'b00,6'b000001,0));
      add("jal_wb",     O_JAL, 0, 0, ex(3'd5, 0,0,0,0,1,1,0,0,2'b00,0,1,2'b10,6'b000001,0));
      // JALR
      fetch_row("jalr_fetch", O_JALR);
      add("jalr_dec",   O_JALR, 0, 0, e_dec(6'b010000));
      add("jalr_exec",  O_JALR, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,1,2'b00,1,0,2'b00,6'b010000,0));
      add("jalr_wb",    O_JALR, 0, 0, ex(3'd5, 0,0,0,0,1,1,0,0,2'b00,0,1,2'b10,6'b010000,0));
      // LUI
      fetch_row("lui_fetch", O_LUI);
      add("lui_dec",    O_LUI, 0, 0, e_dec(6'b000010));
      add("lui_exec",   O_LUI, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,1,2'b11,1,0,2'b00,6'b000010,0));
      add("lui_wb",     O_LUI, 0, 0, ex(3'd5, 0,0,0,0,0,0,0,0,2'b00,0,1,2'b00,6'b000010,0));
      // AUIPC
      fetch_row("auipc_fetch", O_AUIPC);
      add("auipc_dec",  O_AUIPC, 0, 0, e_dec(6'b000010));
      add("auipc_exec", O_AUIPC, 1, 0, ex(3'd3, 0,0,0,0,0,0,0,0,2'b00,0,0,2'b00,6'b000010,0));
      add("auipc_wb",   O_AUIPC, 0, 0, ex(3'd5, 0,0,0,0,0,0,0,0,2'b00,0,1,2'b00,6'b000010,0));
      // R-type
      fetch_row("r_fetch", O_R);
      add("r_dec",      O_R, 0, 0, e_dec(6'b000000));
      add("r_exec",     O_R, 0, 0, ex(3'd3, 0,0,0,0,0,0,0,0,2'b10,1,0,2'b00,6'b000000,0));
      add("r_wb",       O_R, 0, 0, ex(3'd5, 0,0,0,0,0,0,0,0,2'b00,0,1,2'b00,6'b000000,0));
      // Illegal opcode
      fetch_row("bad_fetch", O_BAD);
      add("bad_dec",    O_BAD, 0, 0, e_dec(6'b000000));
      add("bad_trap",   O_BAD, 1, 0, ex(3'd6, 0,0,0,0,0,0,0,0,2'b00,0,0,2'b00,6'b0,1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", act, 24'h0);
      rstn = 1'b1;

      foreach (vecs[i]) begin
         Op = vecs[i].op; mem_ack = vecs[i].ack; br_cond = vecs[i].br;
         @(negedge clk);
         chk(vecs[i].name, act, vecs[i].exp);
         @(posedge clk);
         #1;
      end

      // TRAP is absorbing and never requests memory, even with ack toggling
      for (int c = 0; c < 20; c++) begin
         mem_ack = c[0];
         Op = (c < 10) ? O_BAD : O_ADDI;
         @(negedge clk);
         chk("trap_hold", {mem_req, illegal, state}, {1'b0, 1'b1, 3'd6});
         @(posedge clk);
         #1;
      end

      // Reset clears TRAP asynchronously
      rstn = 1'b0;
      #1;
      chk("trap_reset", act, 24'h0);
      @(posedge clk);
      #1;
      rstn = 1'b1; mem_ack = 1'b0;
      @(posedge clk);
      #1;
      chk("post_trap_fetch", act, e_fetch(1'b0));

      // Async reset mid-FETCH drops mem_req before the next edge
      rstn = 1'b0;
      #1;
      chk("midfetch_reset", act, 24'h0);
      @(posedge clk);
      #1;
      chk("reset_held", act, 24'h0);
      rstn = 1'b1;
      @(negedge clk);
      chk("release_idle", act, 24'h0);
      @(posedge clk);
      #1;
      chk("release_fetch", act, e_fetch(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
